// File: rtl/fp_int_conv_pipe.sv
// fp_int_conv_pipe: 2-stage float-like (sign/exp/frac) to two's-complement
// integer converter with valid/ready flow control on both sides.
//
// Value of the operand is (-1)^sign * frac * 2^(exp - EXP_BIAS).
//   S1: align frac by d = exp - EXP_BIAS, capture the first dropped bit as
//       the round bit, register together with sign and round_mode.
//   S2: optional round-half-away-from-zero, saturate, negate, register.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake (sign, exp, frac, round_mode)
//   out_valid / out_ready result handshake (int_num, ovf)
//   sat_cnt               saturating count of delivered results with ovf=1
module fp_int_conv_pipe #(
  parameter int EXP_W    = 4,
  parameter int FRAC_W   = 8,
  parameter int INT_W    = 8,
  parameter int EXP_BIAS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [FRAC_W-1:0] frac,
  input  logic              round_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INT_W-1:0]  int_num,
  output logic              ovf,
  output logic [15:0]       sat_cnt
);

  localparam int STAGES = 2;
  // Largest left shift is 2^EXP_W-1, so this width never drops a bit.
  localparam int MAG_W  = FRAC_W + (1 << EXP_W);
  // Signed width wide enough for exp - EXP_BIAS with a 32-bit bias.
  localparam int DW     = EXP_W + 34;
  // Compare width: rounded magnitude (one carry bit) or INT_W+1, whichever is larger.
  localparam int CW     = (MAG_W + 1 > INT_W + 1) ? MAG_W + 1 : INT_W + 1;

  localparam logic [CW-1:0] POS_LIM = {{(CW-INT_W+1){1'b0}}, {(INT_W-1){1'b1}}};
  localparam logic [CW-1:0] NEG_LIM = POS_LIM + CW'(1);

  // valid bit per stage; vld_pipe[STAGES] is the output register
  logic [STAGES:1] vld_pipe;
  logic            s1_adv, s2_adv;

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];

  // ---------------- S1: alignment ----------------
  logic signed [DW-1:0] d, nd;
  logic [MAG_W-1:0]     frac_w, mag_c, rnd_tmp;
  logic                 rnd_c;

  assign d      = $signed({{(DW-EXP_W){1'b0}}, exp}) - DW'(EXP_BIAS);
  assign nd     = -d;
  assign frac_w = MAG_W'(frac);

  always_comb begin
    mag_c   = '0;
    rnd_c   = 1'b0;
    rnd_tmp = '0;
    if (!d[DW-1]) begin
      mag_c = frac_w << d;
    end else if (nd <= DW'(FRAC_W)) begin
      // right shift; the last bit shifted out is the round bit
      mag_c   = frac_w >> nd;
      rnd_tmp = frac_w >> (nd - DW'(1));
      rnd_c   = rnd_tmp[0];
    end
  end

  logic [MAG_W-1:0] s1_mag;
  logic             s1_rnd, s1_sign, s1_rm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_mag      <= '0;
      s1_rnd      <= 1'b0;
      s1_sign     <= 1'b0;
      s1_rm       <= 1'b0;
    end else if (s1_adv) begin
      vld_pipe[1] <= in_valid;
      if (in_valid) begin
        s1_mag  <= mag_c;
        s1_rnd  <= rnd_c;
        s1_sign <= sign;
        s1_rm   <= round_mode;
      end
    end
  end

  // ---------------- S2: round, saturate, negate ----------------
  logic [CW-1:0]    mag_r;
  logic [INT_W-1:0] res_c;
  logic             ovf_c;

  assign mag_r = CW'(s1_mag) + CW'(s1_rm & s1_rnd);

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    if (mag_r == '0) begin
      res_c = '0;
    end else if (!s1_sign) begin
      if (mag_r > POS_LIM) begin
        res_c = {1'b0, {(INT_W-1){1'b1}}};
        ovf_c = 1'b1;
      end else begin
        res_c = mag_r[INT_W-1:0];
      end
    end else begin
      // magnitude exactly 2^(INT_W-1) is representable as the most negative value
      if (mag_r > NEG_LIM) begin
        res_c = {1'b1, {(INT_W-1){1'b0}}};
        ovf_c = 1'b1;
      end else begin
        res_c = -mag_r[INT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      int_num     <= '0;
      ovf         <= 1'b0;
    end else if (s2_adv) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        int_num <= res_c;
        ovf     <= ovf_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (out_valid && out_ready && ovf && (sat_cnt != 16'hFFFF))
      sat_cnt <= sat_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fp_int_conv_pipe.sv
// Bench for fp_int_conv_pipe (default parameters): directed vectors,
// randomized traffic against an arithmetic reference model, back-pressure
// and mid-flight reset.
module tb_fp_int_conv_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       sign;
  logic [3:0] exp;
  logic [7:0] frac;
  logic       round_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] int_num;
  logic       ovf;
  logic [15:0] sat_cnt;

  int tests = 0;
  int fails = 0;
  int sat_exp = 0;

  typedef struct packed {
    logic [7:0] r;
    logic       o;
  } res_t;

  fp_int_conv_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .exp(exp), .frac(frac), .round_mode(round_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .int_num(int_num), .ovf(ovf), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  // value = (-1)^s * f * 2^(e-10), aligned/rounded then clamped to int8
  function automatic res_t model(input bit s, input int e, input int f, input bit rm);
    res_t   res;
    int     dd, nd;
    longint m, v;
    int     rb;
    dd = e - 10;
    rb = 0;
    if (dd >= 0) begin
      m = longint'(f) * (longint'(1) << dd);
    end else begin
      nd = -dd;
      if (nd > 8) m = 0;
      else begin
        m  = f / (1 << nd);
        rb = (f / (1 << (nd - 1))) % 2;
      end
    end
    if (rm) m = m + rb;
    v = s ? -m : m;
    res.o = 1'b0;
    if (v > 127)       begin v = 127;  res.o = 1'b1; end
    else if (v < -128) begin v = -128; res.o = 1'b1; end
    res.r = v[7:0];
    return res;
  endfunction

  // Send one operand into an empty pipe and wait for its result.
  task automatic run_op(input bit s, input logic [3:0] e, input logic [7:0] f, input bit rm,
                        output logic [7:0] r, output logic o, output int lat);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; sign = s; exp = e; frac = f; round_mode = rm; out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1; r = 'x; o = 'x;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; r = int_num; o = ovf; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sign = 0; exp = 0; frac = 0; round_mode = 0;
    #12;
    tests++;
    if (out_valid !== 1'b0 || int_num !== 8'h00 || ovf !== 1'b0 || sat_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_state got ov=%b int=%h ovf=%b sat=%0d want 0/00/0/0",
               out_valid, int_num, ovf, sat_cnt);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    bit         vs [8] = '{0, 0, 0, 1, 1, 0, 0, 1};
    logic [3:0] ve [8] = '{10, 9, 9, 9, 10, 10, 15, 0};
    logic [7:0] vf [8] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h80, 8'h80, 8'hFF, 8'hFF};
    bit         vr [8] = '{0, 0, 1, 1, 0, 0, 0, 1};
    logic [7:0] er [8] = '{8'h55, 8'h2A, 8'h2B, 8'hD5, 8'h80, 8'h7F, 8'h7F, 8'h00};
    bit         eo [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
    logic [7:0] r;
    logic       o;
    int         lat;
    for (int i = 0; i < 8; i++) begin
      run_op(vs[i], ve[i], vf[i], vr[i], r, o, lat);
      tests++;
      if (lat != 2 || r !== er[i] || o !== eo[i]) begin
        fails++;
        $display("FAIL directed_%0d got lat=%0d int=%h ovf=%b want lat=2 int=%h ovf=%b",
                 i, lat, r, o, er[i], eo[i]);
      end
      if (i == 6) begin
        @(posedge clk); @(negedge clk);
        tests++;
        if (sat_cnt !== 16'd2) begin
          fails++; $display("FAIL directed_sat_cnt got %0d want 2", sat_cnt);
        end
      end
    end
    @(posedge clk); @(negedge clk);
    sat_exp = 2;
  endtask

  task automatic test_random();
    res_t q[$];
    res_t e, got;
    int   n;
    bit   nv;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      tests++;
      if (sat_cnt !== 16'(sat_exp)) begin
        fails++; $display("FAIL rand_sat_cnt got %0d want %0d", sat_cnt, sat_exp);
      end
      if (out_valid && out_ready) begin
        got.r = int_num; got.o = ovf;
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rand_extra got %h want none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            fails++; $display("FAIL rand_data got int=%h ovf=%b want int=%h ovf=%b",
                              got.r, got.o, e.r, e.o);
          end
          if (e.o) sat_exp++;
        end
      end
      nv = 1'b0;
      if (in_valid && in_ready) begin
        q.push_back(model(sign, int'(exp), int'(frac), round_mode));
        nv = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 9) < 7);
      if (nv || !in_valid) begin
        in_valid   = ($urandom_range(0, 9) < 7) && (c < 380);
        sign       = 1'($urandom);
        exp        = 4'($urandom);
        frac       = 8'($urandom);
        round_mode = 1'($urandom);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      if (out_valid) begin
        e = q.pop_front();
        tests++;
        if (int_num !== e.r || ovf !== e.o) begin
          fails++; $display("FAIL rand_drain got int=%h ovf=%b want int=%h ovf=%b",
                            int_num, ovf, e.r, e.o);
        end
        if (e.o) sat_exp++;
      end
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++; $display("FAIL rand_timeout got %0d pending want 0", q.size());
    end
    @(posedge clk); @(negedge clk);
    tests++;
    if (sat_cnt !== 16'(sat_exp)) begin
      fails++; $display("FAIL rand_sat_final got %0d want %0d", sat_cnt, sat_exp);
    end
  endtask

  task automatic test_back_to_back();
    bit         os [3];
    logic [3:0] oe [3];
    logic [7:0] of [3];
    bit         orm[3];
    res_t       q[$];
    res_t       e;
    int         idx, acc, got, n;
    logic [7:0] held;
    bit         seen, nv;
    for (int i = 0; i < 3; i++) begin
      os[i] = 1'($urandom); oe[i] = 4'($urandom_range(6, 12));
      of[i] = 8'($urandom); orm[i] = 1'($urandom);
      q.push_back(model(os[i], int'(oe[i]), int'(of[i]), orm[i]));
    end
    @(posedge clk); #1;
    out_ready = 1'b0; idx = 0; acc = 0; seen = 0; held = '0;
    in_valid = 1'b1; sign = os[0]; exp = oe[0]; frac = of[0]; round_mode = orm[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (!seen) begin held = int_num; seen = 1'b1; end
        else begin
          tests++;
          if (int_num !== held) begin
            fails++; $display("FAIL b2b_hold got %h want %h", int_num, held);
          end
        end
      end
      nv = in_valid && in_ready;
      if (nv) acc++;
      @(posedge clk); #1;
      if (nv) begin
        idx++;
        if (idx < 3) begin
          sign = os[idx]; exp = oe[idx]; frac = of[idx]; round_mode = orm[idx];
        end else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    tests++;
    if (acc != 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || int_num !== q[0].r) begin
      fails++;
      $display("FAIL b2b_stall got acc=%0d rdy=%b ov=%b int=%h want 2/0/1/%h",
               acc, in_ready, out_valid, int_num, q[0].r);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    got = 0; n = 0;
    while (got < 3 && n < 30) begin
      @(negedge clk);
      if (out_valid) begin
        e = q.pop_front();
        tests++;
        if (int_num !== e.r || ovf !== e.o) begin
          fails++; $display("FAIL b2b_order_%0d got int=%h ovf=%b want int=%h ovf=%b",
                            got, int_num, ovf, e.r, e.o);
        end
        if (e.o) sat_exp++;
        got++;
      end
      nv = in_valid && in_ready;
      @(posedge clk); #1;
      if (nv) begin
        idx++;
        if (idx < 3) begin
          sign = os[idx]; exp = oe[idx]; frac = of[idx]; round_mode = orm[idx];
        end else in_valid = 1'b0;
      end
      n++;
    end
    tests++;
    if (got != 3) begin
      fails++; $display("FAIL b2b_timeout got %0d want 3", got);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    sign = 1'b0; exp = 4'd15; frac = 8'hFF; round_mode = 1'b0;
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || sat_cnt !== 16'h0 || int_num !== 8'h00 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got ov=%b sat=%0d int=%h ovf=%b want 0/0/00/0",
               out_valid, sat_cnt, int_num, ovf);
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_mid_ready got %b want 1", in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (out_valid !== 1'b0) begin
        fails++; $display("FAIL reset_mid_stale got %b want 0", out_valid);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
